// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side handshake bundle of the unified memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_ready, if_rdata, if_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rdata, d_stall,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_ready, if_rdata, if_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rdata, d_stall,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store; data side wins contention.
// Optional IF anti-starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_D  = 3'd2,
        ST_RESP_IF = 3'd3,
        ST_RESP_D  = 3'd4
    } state_t;

    state_t            state_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_ready_r;
    logic              d_ready_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;
    logic              kill_r;
    logic              grant_d_s;
    logic              grant_if_s;
    logic              if_ready_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    logic [CNT_W-1:0] starve_cnt_r;
    logic             contested_s;

    assign contested_s = bus.d_req & bus.if_req & ~bus.if_kill;

    // Counts consecutive contested data wins; any fetch grant or uncontested data grant clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_if_s) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_d_s) begin
            starve_cnt_r <= contested_s ? (starve_cnt_r + CNT_W'(1)) : {CNT_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`endif

    // Arbitration decision, only meaningful while the port is idle
    always_comb begin
        grant_d_s  = 1'b0;
        grant_if_s = 1'b0;
        if (state_r == ST_IDLE) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (contested_s && (starve_cnt_r == STARVE_LIM)) begin
                grant_if_s = 1'b1;
            end else
`endif
            if (bus.d_req) begin
                grant_d_s = 1'b1;
            end else if (bus.if_req && !bus.if_kill) begin
                grant_if_s = 1'b1;
            end else begin
                grant_d_s  = 1'b0;
                grant_if_s = 1'b0;
            end
        end else begin
            grant_d_s  = 1'b0;
            grant_if_s = 1'b0;
        end
    end

    // Transaction sequencer: grant, wait for ack, one response cycle, back to idle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            if_ready_r  <= 1'b0;
            d_ready_r   <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r   <= {DATA_W{1'b0}};
            kill_r      <= 1'b0;
        end else begin
            if_ready_r <= 1'b0;
            d_ready_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    kill_r <= 1'b0;
                    if (grant_d_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= bus.d_we;
                        mem_addr_r  <= bus.d_addr;
                        mem_wdata_r <= bus.d_wdata;
                        state_r     <= ST_BUSY_D;
                    end else if (grant_if_s) begin
                        mem_req_r  <= 1'b1;
                        mem_we_r   <= 1'b0;
                        mem_addr_r <= bus.if_addr;
                        state_r    <= ST_BUSY_IF;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY_IF: begin
                    if (bus.if_kill) begin
                        kill_r <= 1'b1;
                    end else begin
                        kill_r <= kill_r;
                    end
                    if (bus.mem_ack) begin
                        if_rdata_r <= bus.mem_rdata;
                        mem_req_r  <= 1'b0;
                        if_ready_r <= ~(kill_r | bus.if_kill);
                        state_r    <= ST_RESP_IF;
                    end else begin
                        state_r <= ST_BUSY_IF;
                    end
                end
                ST_BUSY_D: begin
                    if (bus.mem_ack) begin
                        d_rdata_r <= bus.mem_rdata;
                        mem_req_r <= 1'b0;
                        d_ready_r <= 1'b1;
                        state_r   <= ST_RESP_D;
                    end else begin
                        state_r <= ST_BUSY_D;
                    end
                end
                ST_RESP_IF: begin
                    kill_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                ST_RESP_D: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    kill_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // A kill arriving in the response cycle itself must still squash the fetch
    assign if_ready_s    = if_ready_r & ~bus.if_kill;
    assign bus.if_ready  = if_ready_s;
    assign bus.d_ready   = d_ready_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_stall  = bus.if_req & ~if_ready_s;
    assign bus.d_stall   = bus.d_req & ~d_ready_r;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between the pipeline stages and the memory model.
- Serialises transactions through a small FSM and drives per-stage stall outputs. The pipeline ORs these stalls with the load-use/ecall hazard stall.
- Data accesses win contested cycles because they belong to the older instruction.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive contested D wins allowed before IF is forced through (used only with the optional feature).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- if_req  input  1  IF stage requests a fetch; held with if_addr stable until if_ready.
- if_addr  input  ADDR_W  fetch address.
- if_kill  input  1  discard the pending or in-flight fetch (branch flush).
- if_ready  output  1  one-cycle pulse; if_rdata valid.
- if_rdata  output  DATA_W  fetched instruction, registered.
- if_stall  output  1  if_req & ~if_ready.
- d_req  input  1  MEM stage request; held with d_we, d_addr and d_wdata stable until d_ready.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_ready  output  1  one-cycle pulse; d_rdata valid for loads.
- d_rdata  output  DATA_W  load data, registered.
- d_stall  output  1  d_req & ~d_ready.
- mem_req  output  1  transaction active; held until mem_ack.
- mem_we  output  1  write enable of the active transaction.
- mem_addr  output  ADDR_W  address of the active transaction.
- mem_wdata  output  DATA_W  write data of the active transaction.
- mem_rdata  input  DATA_W  read data; valid when mem_ack = 1.
- mem_ack  input  1  one-cycle completion pulse from memory.

Behaviour:
- States: IDLE, BUSY_IF, BUSY_D, RESP_IF, RESP_D.
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_ready, d_ready = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - kill flag = 0; starvation counter = 0.
- IDLE:
  - d_req = 1 → latch d_we/d_addr/d_wdata into the mem_* registers; go to BUSY_D.
  - else if_req = 1 and if_kill = 0 → latch if_addr, mem_we = 0; go to BUSY_IF.
  - else stay in IDLE.
- BUSY_x:
  - mem_req = 1; mem_* held stable.
  - On mem_ack: latch mem_rdata into x_rdata, drop mem_req, go to RESP_x.
  - mem_ack while in IDLE or RESP_x is ignored.
- RESP_x:
  - x_ready = 1 for exactly this cycle; requests are not sampled; next state IDLE.
  - Requester may hold or change req from the following cycle. IDLE re-arbitrates then.
- Latency:
  - Request first seen in IDLE at cycle t, mem_ack at cycle t+1+k (k ≥ 0) → ready at cycle t+2+k.
  - Minimum 2 cycles.
  - Back-to-back throughput: one transaction per 3+k cycles.
- Stores: d_ready pulses on completion; d_rdata is updated with mem_rdata regardless of d_we.
- if_kill:
  - In IDLE: suppresses the IF grant.
  - In BUSY_IF: sets the kill flag. The transaction still completes (memory cannot abort).
  - In RESP_IF: suppresses if_ready that cycle.
  - When the kill flag is set, if_ready is suppressed in RESP_IF; the flag clears on entering IDLE.
  - if_rdata is still updated when killed.
- Simultaneous d_req and if_req in IDLE: D wins (subject to the optional feature). IF waits with if_stall = 1.
- Requests asserted while the other requester's transaction is in flight are served in the next IDLE cycle.
- Reset mid-transaction:
  - Next state IDLE; all outputs return to reset values on that edge.
  - A late mem_ack is ignored; no ready pulse is generated.
- if_stall and d_stall are combinational from req and ready.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width clog2(STARVE_MAX+1) increments on each D grant made while if_req = 1 and if_kill = 0.
  - It clears on any IF grant, and on any D grant made with no IF contender.
  - When the counter equals STARVE_MAX and both requests are present in IDLE, IF is granted instead; the counter then clears.
- Undefined: the counter is absent; D always wins contested cycles, and IF can starve indefinitely.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, memory acks with 0x00500093 in the first BUSY cycle → if_ready pulses 2 cycles after the request with if_rdata=0x00500093; mem_we=0 throughout.
- Store with wait states: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, ack after 3 BUSY cycles → mem_addr/mem_wdata/mem_we held stable for all 3 cycles; d_ready at cycle t+5 (k=3); d_stall=1 until then.
- Contention: if_req and d_req both set at t, immediate acks → d_ready at t+2, IF granted at t+3, if_ready at t+5; if_stall=1 from t to t+4.
- Kill in flight: fetch in BUSY_IF, pulse if_kill one cycle, then ack → no if_ready pulse; state returns to IDLE; a new if_req is served normally.
- Reset mid-transaction: reset asserted in BUSY_D, then mem_ack one cycle later → state IDLE; mem_req=0; d_ready never pulses.
- Starvation guard (macro defined, STARVE_MAX=4): d_req and if_req held high, immediate acks → grant order D,D,D,D,IF,D…; without the macro, all grants go to D.
